// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts a byte address on MAR and returns the
// addressed word on MBR after WAIT_STATES wait states, flagging bad addresses.
module imem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [31:0]                    MAR,
  output logic [31:0]                    MBR,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic                           rsp_err,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
  input  logic [31:0]                    ld_data
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam bit ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] WAIT_LOAD = ZERO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state;
  logic [3:0]     wait_cnt;
  logic [AW-1:0]  addr_q;
  logic           req_err;
  logic [31:0]    mem [DEPTH_WORDS];

  // Upper MAR bits beyond the array are checked, never dropped, so no aliasing.
  assign req_err = (MAR[1:0] != 2'b00) || (|MAR[31:AW+2]);

  // NOTE: the array has no reset branch; clearing a memory on reset would turn
  // it into a huge flop bank, and program contents are loaded explicitly anyway.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  // NOTE: all state here uses <=, so the mem[] read below sees the value from
  // before any load write on the same edge (read-before-write for free).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      MBR       <= 32'h0;
      rsp_err   <= 1'b0;
      wait_cnt  <= 4'd0;
      addr_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= MAR[AW+1:2];
            req_ready <= 1'b0;
            if (req_err || ZERO_WAIT) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= req_err;
              MBR       <= req_err ? 32'h0 : mem[MAR[AW+1:2]];
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            MBR       <= mem[addr_q];
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          // MBR is deliberately left alone here so it stays stable under stall.
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed cases from the test plan plus
// randomized reads compared against an array-based reference model.
module tb_imem_responder;

  localparam int WS    = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, ld_en;
  logic [31:0] MAR, MBR, ld_data;
  logic [7:0]  ld_addr;

  logic        z_req_valid, z_req_ready, z_rsp_valid, z_rsp_ready, z_rsp_err, z_ld_en;
  logic [31:0] z_MAR, z_MBR, z_ld_data;
  logic [7:0]  z_ld_addr;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          last_accept = -1;
  logic [31:0] ref_mem [DEPTH];

  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .MAR(MAR), .MBR(MBR), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_err(rsp_err), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  imem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .MAR(z_MAR), .MBR(z_MBR), .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_err(z_rsp_err), .ld_en(z_ld_en), .ld_addr(z_ld_addr), .ld_data(z_ld_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic load_word(input logic [7:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); @(negedge clk);
    ld_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // One complete transaction, entered and left at a negedge. ld_k >= 0 pulses a
  // load to the same word across the k-th edge after acceptance; bp_ld writes it
  // during the first stall cycle.
  task automatic do_read(input logic [31:0] addr, input int stall, input int ld_k,
                         input bit bp_ld, input logic [31:0] ld_val, input bit chk_gap);
    logic        exp_err;
    logic [31:0] exp_mbr;
    logic [7:0]  w;
    int          n, k, lat;
    w       = addr[9:2];
    exp_err = (addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH);
    exp_mbr = exp_err ? 32'h0 : ref_mem[w];
    lat     = exp_err ? 0 : WS;
    check("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; MAR = addr; rsp_ready = (stall == 0);
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; MAR = $urandom;
    n = cyc;
    if (chk_gap && last_accept >= 0) check("accept_gap", n - last_accept, 2 + WS);
    last_accept = n;
    check("req_ready_busy", {31'b0, req_ready}, 32'd0);
    k = 0;
    while (!rsp_valid && k < 40) begin
      if (k == ld_k) begin ld_en = 1'b1; ld_addr = w; ld_data = ld_val; end
      @(posedge clk); @(negedge clk);
      if (ld_en) begin ld_en = 1'b0; ref_mem[w] = ld_val; end
      k++;
    end
    // rsp_valid must first be sampled high at edge N+1+latency.
    check("rsp_edge", cyc + 1, n + 1 + lat);
    check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("mbr", MBR, exp_mbr);
    check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
    for (int i = 0; i < stall; i++) begin
      if (i == 0 && bp_ld) begin ld_en = 1'b1; ld_addr = w; ld_data = ld_val; end
      @(posedge clk); @(negedge clk);
      if (ld_en) begin ld_en = 1'b0; ref_mem[w] = ld_val; end
      check("bp_valid", {31'b0, rsp_valid}, 32'd1);
      check("bp_mbr", MBR, exp_mbr);
      check("bp_err", {31'b0, rsp_err}, {31'b0, exp_err});
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("post_valid", {31'b0, rsp_valid}, 32'd0);
    check("post_err", {31'b0, rsp_err}, 32'd0);
    check("post_req_ready", {31'b0, req_ready}, 32'd1);
    check("post_mbr", MBR, exp_mbr);
  endtask

  initial begin
    logic [31:0] a;
    int          seen;
    rst_n = 1'b0;
    req_valid = 0; rsp_ready = 0; MAR = 0; ld_en = 0; ld_addr = 0; ld_data = 0;
    z_req_valid = 0; z_rsp_ready = 0; z_MAR = 0; z_ld_en = 0; z_ld_addr = 0; z_ld_data = 0;
    #12;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_mbr", MBR, 32'h0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) load_word(8'(i), $urandom);

    // Basic read, back to back.
    load_word(8'd0, 32'h00000013);
    load_word(8'd1, 32'h00100093);
    load_word(8'd2, 32'h00200113);
    last_accept = -1;
    do_read(32'h0, 0, -1, 0, 0, 1);
    do_read(32'h4, 0, -1, 0, 0, 1);
    do_read(32'h8, 0, -1, 0, 0, 1);

    // Error and boundary addresses.
    load_word(8'd255, 32'h0FF0_0FF0);
    do_read(32'h2,   0, -1, 0, 0, 0);
    do_read(32'h400, 0, -1, 0, 0, 0);
    do_read(32'h3FC, 0, -1, 0, 0, 0);
    do_read(32'h3,   2, -1, 0, 0, 0);

    // Back-pressure with a load to the word being returned, then re-read.
    do_read(32'h8, 5, -1, 1, 32'hDEADBEEF, 0);
    do_read(32'h8, 0, -1, 0, 0, 0);

    // Load to word 1 on the RESP-entry edge: old value returned, new on re-read.
    do_read(32'h4, 0, WS - 1, 0, 32'h1234_5678, 0);
    do_read(32'h4, 0, -1, 0, 0, 0);

    // Reset mid-WAIT aborts the request with no clock edge needed.
    req_valid = 1'b1; MAR = 32'h0; rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("abort_req_ready", {31'b0, req_ready}, 32'd1);
    check("abort_mbr", MBR, 32'h0);
    #2;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("abort_no_rsp", seen, 0);

    // Randomized reads against the reference array.
    for (int i = 0; i < 40; i++) begin
      int r, st;
      bit bp;
      r = $urandom_range(0, 9);
      if (r < 7)      a = {22'b0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
      else if (r < 8) a = {22'b0, 8'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
      else begin
        a = $urandom;
        if (a < 32'h400) a = a + 32'h400;
      end
      st = $urandom_range(0, 3);
      bp = (st > 0) && ($urandom_range(0, 1) == 1);
      do_read(a, st, -1, bp, $urandom, 0);
    end

    // Zero-wait build with req_valid held: alternates RESP / IDLE every edge.
    z_ld_en = 1'b1; z_ld_addr = 8'd5; z_ld_data = 32'hCAFE_0005;
    @(posedge clk); @(negedge clk);
    z_ld_en = 1'b0;
    check("z_req_ready_idle", {31'b0, z_req_ready}, 32'd1);
    z_req_valid = 1'b1; z_MAR = 32'd20; z_rsp_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      logic exp_v;
      @(posedge clk); @(negedge clk);
      exp_v = (k % 2) == 1;
      check("z_rsp_valid", {31'b0, z_rsp_valid}, {31'b0, exp_v});
      check("z_req_ready", {31'b0, z_req_ready}, {31'b0, !exp_v});
      check("z_mbr", z_MBR, 32'hCAFE_0005);
      check("z_rsp_err", {31'b0, z_rsp_err}, 32'd0);
    end
    z_req_valid = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
